// File: rtl/pulse_interval_meter.sv
// -----------------------------------------------------------------------------
// pulse_interval_meter
//
// Coarse interval meter for a start/stop pulse pair. It counts clk cycles from
// the rising edge of start to the rising edge of the next stop. Each result,
// tagged with a timeout flag, is queued in a small first-word-fall-through
// FIFO and drained over a valid/ready stream.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst_n          synchronous reset, active low
//   enable         measurement enable; dropping it aborts a running count
//   start, stop    pulse inputs, already synchronous to clk
//   timeout_cycles timeout limit in cycles, 0 disables the timeout
//   m_data         interval of the FIFO head entry (0 while empty)
//   m_timeout      head entry was ended by timeout rather than by stop
//   m_valid        FIFO not empty
//   m_ready        consumer takes the head entry
//   busy           a measurement is in progress
//   fifo_level     number of queued entries
//   drop_count     results lost to a full FIFO, saturating at 255
// -----------------------------------------------------------------------------
module pulse_interval_meter #(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        start,
    input  logic                        stop,
    input  logic [CNT_W-1:0]            timeout_cycles,
    output logic [CNT_W-1:0]            m_data,
    output logic                        m_timeout,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, COUNT} state_t;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic             start_d_reg, stop_d_reg;
    logic             start_edge, stop_edge;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] limit;
    logic             push_req_reg, push_req_next;
    logic [CNT_W-1:0] push_data_reg, push_data_next;
    logic             push_to_reg, push_to_next;

    assign start_edge = start & ~start_d_reg;
    assign stop_edge  = stop & ~stop_d_reg;

    // A disabled timeout behaves like a limit at the counter's ceiling, so the
    // count ends with a timeout entry instead of wrapping.
    assign limit = (timeout_cycles == '0) ? CNT_MAX : timeout_cycles;

    assign busy = (state_reg == COUNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            // History loads 1 so a level held high across reset is not an edge.
            start_d_reg   <= 1'b1;
            stop_d_reg    <= 1'b1;
            cnt_reg       <= '0;
            push_req_reg  <= 1'b0;
            push_data_reg <= '0;
            push_to_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            start_d_reg   <= start;
            stop_d_reg    <= stop;
            cnt_reg       <= cnt_next;
            push_req_reg  <= push_req_next;
            push_data_reg <= push_data_next;
            push_to_reg   <= push_to_next;
        end
    end

    // cnt_reg holds the interval k that a stop edge at the current clk edge
    // would produce: it is loaded with 1 on the start edge and advances once
    // per cycle while counting.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        push_req_next  = 1'b0;
        push_data_next = push_data_reg;
        push_to_next   = push_to_reg;
        case (state_reg)
            IDLE: begin
                if (enable && start_edge) begin
                    state_next = COUNT;
                    cnt_next   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (stop_edge) begin
                    // Stop takes priority over a timeout in the same cycle.
                    push_req_next  = 1'b1;
                    push_data_next = cnt_reg;
                    push_to_next   = 1'b0;
                    state_next     = IDLE;
                end else if (cnt_reg >= limit) begin
                    // >= keeps a limit lowered mid-count from being skipped.
                    push_req_next  = 1'b1;
                    push_data_next = limit;
                    push_to_next   = 1'b1;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] data_mem [FIFO_DEPTH];
    logic             to_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [7:0]       drop_reg;
    logic             fifo_full, pop, wr_en, drop;

    assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
    assign m_valid    = (level_reg != '0);
    assign pop        = m_valid & m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en      = push_req_reg & (~fifo_full | pop);
    assign drop       = push_req_reg & fifo_full & ~pop;
    assign m_data     = m_valid ? data_mem[rd_ptr_reg] : '0;
    assign m_timeout  = m_valid & to_mem[rd_ptr_reg];
    assign fifo_level = level_reg;
    assign drop_count = drop_reg;

    // Storage carries no reset; the outputs are gated by m_valid instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr_reg] <= push_data_reg;
            to_mem[wr_ptr_reg]   <= push_to_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            drop_reg   <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                level_reg <= level_reg + LVL_W'(1);
            end else if (!wr_en && pop) begin
                level_reg <= level_reg - LVL_W'(1);
            end
            if (drop && (drop_reg != 8'hFF)) begin
                drop_reg <= drop_reg + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_interval_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_interval_meter
//
// Self-checking bench for pulse_interval_meter: a table of single-pair
// measurements, hand-written sequences for FIFO full/drop, simultaneous
// edges, re-arm, abort and reset, then a randomized run compared cycle by
// cycle with a queue-based reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_interval_meter;
    localparam int CNT_W = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n, enable, start, stop, m_ready;
    logic [CNT_W-1:0] timeout_cycles;
    logic [CNT_W-1:0] m_data;
    logic             m_timeout, m_valid, busy;
    logic [2:0]       fifo_level;
    logic [7:0]       drop_count;

    int errors = 0;
    int checks = 0;

    pulse_interval_meter #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .start          (start),
        .stop           (stop),
        .timeout_cycles (timeout_cycles),
        .m_data         (m_data),
        .m_timeout      (m_timeout),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .busy           (busy),
        .fifo_level     (fifo_level),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: time is an edge index; a measurement is the
    // difference of two edge indices; the FIFO is a queue.
    // ------------------------------------------------------------------
    typedef struct {
        int data;
        bit to;
    } entry_t;

    entry_t mq[$];
    bit     md_armed, md_pend, md_prev_start, md_prev_stop;
    entry_t md_pend_e;
    longint md_es, md_edge;
    int     md_drops;

    initial begin
        md_armed = 0; md_pend = 0; md_prev_start = 1; md_prev_stop = 1;
        md_es = 0; md_edge = 0; md_drops = 0;
    end

    task automatic model_edge();
        bit se, pe, pop, full, np;
        entry_t ne;
        int k, lim;
        ne = '{data: 0, to: 0};
        np = 0;
        md_edge++;
        if (!rst_n) begin
            mq.delete();
            md_armed = 0; md_pend = 0; md_drops = 0;
            md_prev_start = 1; md_prev_stop = 1;
            return;
        end
        se = start && !md_prev_start;
        pe = stop && !md_prev_stop;
        md_prev_start = start;
        md_prev_stop  = stop;
        pop  = (mq.size() > 0) && m_ready;
        full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (md_pend) begin
            if (full && !pop) begin
                if (md_drops < 255) md_drops++;
            end else begin
                mq.push_back(md_pend_e);
            end
        end
        if (md_armed) begin
            k   = int'(md_edge - md_es);
            lim = (timeout_cycles == 0) ? 65535 : int'(timeout_cycles);
            if (!enable) begin
                md_armed = 0;
            end else if (pe) begin
                np = 1; ne.data = k; ne.to = 0; md_armed = 0;
            end else if (k >= lim) begin
                np = 1; ne.data = lim; ne.to = 1; md_armed = 0;
            end
        end else if (enable && se) begin
            md_armed = 1;
            md_es    = md_edge;
        end
        md_pend   = np;
        md_pend_e = ne;
    endtask

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_pair(input int k, input int ready_at);
        for (int t = 0; t < k + 3; t++) begin
            start = (t == 0);
            stop  = (t == k);
            if (ready_at >= 0) m_ready = (t == ready_at);
            step();
        end
        start = 0; stop = 0;
        if (ready_at >= 0) m_ready = 0;
    endtask

    task automatic run_seq(input logic [15:0] smask, input logic [15:0] pmask, input int n);
        for (int t = 0; t < n; t++) begin
            start = smask[t];
            stop  = pmask[t];
            step();
        end
        start = 0; stop = 0;
    endtask

    task automatic drain4(input string name, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        m_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk({name, "_valid"}, m_valid, 1);
            chk({name, "_data"}, m_data, e[i]);
            $display("%s: beat %0d data=%0d timeout=%0d", name, i, m_data, m_timeout);
            step();
        end
        chk({name, "_empty"}, m_valid, 0);
    endtask

    // ------------------------------------------------------------------
    // Table of single-pair measurements (m_ready held high).
    // k = stop offset from the start edge (0 = no stop).
    // vt = cycle offset at which m_valid first appears.
    // ------------------------------------------------------------------
    typedef struct {
        int k;
        int tmo;
        int exp_data;
        bit exp_to;
        int exp_busy;
        int exp_vt;
    } vec_t;

    localparam int NV = 8;
    vec_t vec[NV];
    int   tmo_set[4];

    initial begin
        int first_t, vcnt, bcnt, got_d, got_to, nt;

        vec[0] = '{k: 6,  tmo: 0,  exp_data: 6,  exp_to: 0, exp_busy: 6,  exp_vt: 7};
        vec[1] = '{k: 1,  tmo: 0,  exp_data: 1,  exp_to: 0, exp_busy: 1,  exp_vt: 2};
        vec[2] = '{k: 0,  tmo: 10, exp_data: 10, exp_to: 1, exp_busy: 10, exp_vt: 11};
        vec[3] = '{k: 10, tmo: 10, exp_data: 10, exp_to: 0, exp_busy: 10, exp_vt: 11};
        vec[4] = '{k: 9,  tmo: 10, exp_data: 9,  exp_to: 0, exp_busy: 9,  exp_vt: 10};
        vec[5] = '{k: 0,  tmo: 1,  exp_data: 1,  exp_to: 1, exp_busy: 1,  exp_vt: 2};
        vec[6] = '{k: 20, tmo: 5,  exp_data: 5,  exp_to: 1, exp_busy: 5,  exp_vt: 6};
        vec[7] = '{k: 3,  tmo: 4,  exp_data: 3,  exp_to: 0, exp_busy: 3,  exp_vt: 4};
        tmo_set[0] = 0; tmo_set[1] = 6; tmo_set[2] = 15; tmo_set[3] = 40;

        // ---------------- reset state ----------------
        rst_n = 0; enable = 1; start = 0; stop = 0; m_ready = 1; timeout_cycles = '0;
        step(); step();
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_timeout", m_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_count, 0);
        rst_n = 1;
        step();

        // ---------------- table-driven single pairs ----------------
        for (int r = 0; r < NV; r++) begin
            first_t = -1; vcnt = 0; bcnt = 0; got_d = 0; got_to = 0;
            timeout_cycles = CNT_W'(vec[r].tmo);
            nt = ((vec[r].k > vec[r].exp_vt) ? vec[r].k : vec[r].exp_vt) + 4;
            for (int t = 0; t < nt; t++) begin
                start = (t == 0);
                stop  = (vec[r].k != 0) && (t == vec[r].k);
                step();
                if (busy) bcnt++;
                if (m_valid) begin
                    vcnt++;
                    if (first_t < 0) begin
                        first_t = t; got_d = int'(m_data); got_to = int'(m_timeout);
                    end
                end
            end
            start = 0; stop = 0;
            chk("vec_latency", first_t, vec[r].exp_vt);
            chk("vec_data", got_d, vec[r].exp_data);
            chk("vec_timeout", got_to, vec[r].exp_to);
            chk("vec_busy_cycles", bcnt, vec[r].exp_busy);
            chk("vec_valid_cycles", vcnt, 1);
            $display("vec %0d: k=%0d tmo=%0d -> data=%0d timeout=%0d busy=%0d at +%0d",
                     r, vec[r].k, vec[r].tmo, got_d, got_to, bcnt, first_t);
        end
        timeout_cycles = '0;

        // ---------------- start held high through reset ----------------
        rst_n = 0; start = 1;
        step(); step();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("held_start_busy", busy, 0);
        end
        stop = 1; step(); stop = 0;
        step(); step(); step();
        chk("held_start_valid", m_valid, 0);
        chk("held_start_level", fifo_level, 0);
        start = 0; step();
        $display("held start through reset: busy=%0d level=%0d", busy, fifo_level);

        // ---------------- FIFO full / drop ----------------
        m_ready = 0;
        for (int k = 3; k <= 8; k++) run_pair(k, -1);
        chk("full_level", fifo_level, 4);
        chk("full_drop", drop_count, 2);
        $display("fifo fill: level=%0d drops=%0d", fifo_level, drop_count);
        drain4("drain_a", 3, 4, 5, 6);

        // ---------------- full with simultaneous pop ----------------
        m_ready = 0;
        for (int k = 3; k <= 6; k++) run_pair(k, -1);
        chk("fullpop_pre_level", fifo_level, 4);
        run_pair(9, 10);
        chk("fullpop_level", fifo_level, 4);
        chk("fullpop_drop", drop_count, 2);
        $display("full with pop: level=%0d drops=%0d", fifo_level, drop_count);
        drain4("drain_b", 4, 5, 6, 9);

        // ---------------- enable dropped mid-count ----------------
        m_ready = 1;
        for (int t = 0; t < 7; t++) begin
            start  = (t == 0);
            enable = (t < 3);
            step();
            if (t == 2) chk("abort_busy_before", busy, 1);
            if (t == 3) chk("abort_busy_after", busy, 0);
        end
        start = 0; enable = 1;
        step(); step();
        chk("abort_valid", m_valid, 0);
        chk("abort_level", fifo_level, 0);
        $display("abort: busy=%0d level=%0d", busy, fifo_level);

        // ---------------- simultaneous edges and re-arm attempt ----------------
        m_ready = 0;
        run_seq(16'h0001, 16'h0011, 8);
        chk("simul_level", fifo_level, 1);
        chk("simul_data", m_data, 4);
        chk("simul_timeout", m_timeout, 0);
        $display("simultaneous start/stop: data=%0d", m_data);
        run_seq(16'h0009, 16'h0080, 10);
        chk("rearm_level", fifo_level, 2);
        chk("rearm_busy", busy, 0);
        chk("rearm_head", m_data, 4);
        $display("second start ignored: level=%0d", fifo_level);

        // ---------------- reset with entries queued ----------------
        rst_n = 0;
        step();
        chk("qrst_valid", m_valid, 0);
        chk("qrst_level", fifo_level, 0);
        chk("qrst_drop", drop_count, 0);
        chk("qrst_data", m_data, 0);
        rst_n = 1; m_ready = 1;
        step();
        $display("reset with queue: level=%0d drops=%0d", fifo_level, drop_count);

        // ---------------- randomized run against the model ----------------
        rst_n = 0; step(); rst_n = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 5) == 0) start = ~start;
            if ($urandom_range(0, 7) == 0) stop = ~stop;
            m_ready = ($urandom_range(0, 2) == 0);
            enable  = ($urandom_range(0, 99) != 0);
            rst_n   = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 199) == 0) timeout_cycles = CNT_W'(tmo_set[$urandom_range(0, 3)]);
            step();
            chk("rnd_valid", m_valid, (mq.size() > 0));
            chk("rnd_data", m_data, (mq.size() > 0) ? mq[0].data : 0);
            chk("rnd_timeout", m_timeout, (mq.size() > 0) ? int'(mq[0].to) : 0);
            chk("rnd_busy", busy, md_armed);
            chk("rnd_level", fifo_level, mq.size());
            chk("rnd_drop", drop_count, md_drops);
        end
        $display("random run: 4000 cycles, final level=%0d drops=%0d", fifo_level, drop_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_interval_meter.md
Name: pulse_interval_meter

Overview:
Downstream consumer of the test pulse pair. It measures the distance, in clk cycles, from the rising edge of a start pulse to the rising edge of the following stop pulse. Each result, with a timeout flag, goes into a small FIFO and is drained over a valid/ready stream toward the PS-side readout. It provides the coarse-count golden reference against which TDC fine measurements are checked.

Parameters:
CNT_W, 16, width of interval counter and result data
FIFO_DEPTH, 4, result FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
enable  in  1  measurement enable
start  in  1  start pulse, synchronous to clk; no internal synchronizer
stop  in  1  stop pulse, synchronous to clk
timeout_cycles  in  CNT_W  timeout limit in cycles; 0 = timeout disabled
m_data  out  CNT_W  interval result at FIFO head
m_timeout  out  1  head entry ended by timeout, not by stop
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts head entry
busy  out  1  measurement in progress (state COUNT)
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
drop_count  out  8  results lost to full FIFO; saturates at 255

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state IDLE; FIFO empty; m_valid=0; m_data=0; m_timeout=0; busy=0; fifo_level=0; drop_count=0.
  - start/stop edge-history registers load 1, so a level already high at reset release is not treated as an edge.
- Edge detection:
  - A start edge occurs at clk edge e when start is sampled 1 at e and was sampled 0 at e-1. Stop edges are defined the same way.
  - Pulses of any width of 1 or more cycles are accepted.
- FSM states: IDLE, COUNT.
- IDLE:
  - start edge with enable=1 -> COUNT; the start edge is e_s.
  - Stop edges are ignored.
  - A simultaneous start and stop edge arms the measurement; that stop is ignored.
- COUNT:
  - Interval k = e_p - e_s, where e_p is the first stop edge after e_s. Minimum k is 1.
  - Stop edge: push {data=k, timeout=0}, then -> IDLE.
  - Timeout (timeout_cycles != 0): when k would reach timeout_cycles with no stop edge, push {data=timeout_cycles, timeout=1}, then -> IDLE.
  - Stop edge and timeout in the same cycle: the stop result wins (timeout=0).
  - Timeout disabled: counter saturates at all-ones; reaching all-ones pushes {all-ones, timeout=1}, then -> IDLE.
  - Further start edges are ignored (no re-arm).
  - enable=0: abort, no push, -> IDLE next edge.
- Latency: an entry pushed due to edge e_p appears on m_* (m_valid=1 if FIFO was empty) after edge e_p+1.
- Back-to-back measurements: a start edge at the edge the FSM returns to IDLE is not seen. Re-arm needs a start edge at or after the next edge.
- FIFO:
  - Synchronous, first-word-fall-through. m_data/m_timeout are the head entry, stable while m_valid=1 and m_ready=0.
  - Pop on m_valid & m_ready.
  - Push when full with no pop that cycle: result dropped; drop_count += 1, saturating at 255.
  - Push when full with a pop in the same cycle: accepted; level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - m_ready while empty has no effect.
- Reset mid-COUNT or with FIFO non-empty: all state cleared per the reset values; in-flight results are lost.

Test Plan:
- Single pair: start 1-cycle pulse, stop rises 6 cycles later, m_ready=1 -> one entry, data=6, timeout=0; m_valid high for 1 cycle, one cycle after the stop edge.
- Timeout: timeout_cycles=10, start edge, no stop -> entry data=10, timeout=1; busy high exactly 10 cycles. Repeat with stop at k=10 -> data=10, timeout=0.
- FIFO full/drop: m_ready=0; run 6 pairs with k=3,4,5,6,7,8 -> fifo_level=4, drop_count=2. Then m_ready=1 drains 3,4,5,6 in order; m_valid falls after 4 beats.
- Full with simultaneous pop: FIFO full; m_ready pulsed in the same cycle as a push (k=9) -> no drop, level stays 4, 9 is the last entry drained.
- Edge cases:
  - start high through reset release -> no measurement.
  - start and stop rising together in IDLE, then stop 4 cycles later -> data=4.
  - Second start edge during COUNT ignored.
- Abort/reset: enable dropped mid-COUNT -> no entry, busy=0 next cycle. rst_n=0 with 2 entries queued -> m_valid=0, fifo_level=0, drop_count=0.
